// File: rtl/flopr_pkg.sv
// rtl/flopr_pkg.sv - shared constants for the generic pipeline-stage register
package flopr_pkg;

  localparam int FLOPR_DEFAULT_WIDTH = 8;
  localparam int FLOPR_MAX_WIDTH     = 1024;

endpackage

// File: rtl/flopr.sv
// rtl/flopr.sv - enable register with asynchronous active-high reset
// A stall (en=0) holds q; reset overrides both the clock and en.
module flopr
  import flopr_pkg::*;
#(
  parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_flopr.sv
// tb/tb_flopr.sv - self-checking bench for flopr at several widths
module tb_flopr;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         en108, en4, en8, en1, en80;
  logic [107:0] d108, q108;
  logic [3:0]   d4, q4;
  logic [7:0]   d8, q8, d80, q80;
  logic [0:0]   d1, q1;

  flopr #(.WIDTH(108)) u108 (.clk(clk), .reset(reset), .en(en108), .d(d108), .q(q108));
  flopr #(.WIDTH(4))   u4   (.clk(clk), .reset(reset), .en(en4),   .d(d4),   .q(q4));
  flopr #(.WIDTH(8))   u8   (.clk(clk), .reset(reset), .en(en8),   .d(d8),   .q(q8));
  flopr #(.WIDTH(1))   u1   (.clk(clk), .reset(reset), .en(en1),   .d(d1),   .q(q1));
  flopr #(.WIDTH(8), .RESET_VALUE(8'h80)) u80
    (.clk(clk), .reset(reset), .en(en80), .d(d80), .q(q80));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t         stall_tbl[6];
  logic [3:0]   load_tbl[3];
  logic [107:0] exp108;
  logic [0:0]   prev1;

  initial begin
    reset = 1'b1;
    en108 = 1'b0; en4 = 1'b0; en8 = 1'b0; en1 = 1'b0; en80 = 1'b0;
    d108 = '0; d4 = '0; d8 = '0; d1 = '0; d80 = '0;
    #1;
    check("rst_q108", 128'(q108), 128'(0));
    check("rst_q4", 128'(q4), 128'(0));
    check("rst_q8", 128'(q8), 128'(0));
    check("rst_q1", 128'(q1), 128'(0));
    check("rst_q80", 128'(q80), 128'(8'h80));
    @(negedge clk);
    reset = 1'b0;

    // load sequence, 4-bit
    load_tbl[0] = 4'h5; load_tbl[1] = 4'hA; load_tbl[2] = 4'hF;
    en4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d4 = load_tbl[i];
      @(posedge clk); #1;
      check("load_q4", 128'(q4), 128'(load_tbl[i]));
    end

    // stall table, 8-bit
    stall_tbl[0] = '{1'b1, 8'h3C, 8'h3C};
    for (int i = 1; i < 5; i++) stall_tbl[i] = '{1'b0, 8'hFF, 8'h3C};
    stall_tbl[5] = '{1'b1, 8'hFF, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en8 = stall_tbl[i].en;
      d8  = stall_tbl[i].d;
      @(posedge clk); #1;
      check("stall_q8", 128'(q8), 128'(stall_tbl[i].exp));
    end

    // en pulsed between edges must not capture
    @(negedge clk);
    d8 = 8'h11; en8 = 1'b1;
    #1 en8 = 1'b0;
    @(posedge clk); #1;
    check("en_glitch_q8", 128'(q8), 128'(8'hFF));

    // randomized stream against a simple hold/capture model, 108-bit
    exp108 = q108;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      en108 = 1'($urandom_range(0, 1));
      d108  = 108'({$urandom(), $urandom(), $urandom(), $urandom()});
      #1;
      check("nocomb_q108", 128'(q108), 128'(exp108));
      @(posedge clk);
      if (en108) exp108 = d108;
      #1;
      check("rand_q108", 128'(q108), 128'(exp108));
    end

    // width 1 follows toggling d with one cycle of lag
    en1 = 1'b1;
    prev1 = q1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d1 = ~prev1;
      #1;
      check("w1_hold", 128'(q1), 128'(prev1));
      @(posedge clk); #1;
      check("w1_follow", 128'(q1), 128'(d1));
      prev1 = d1;
    end

    // asynchronous reset while q is all-ones, plus reset priority on u8
    @(negedge clk);
    en108 = 1'b1; d108 = '1;
    en8 = 1'b1; d8 = 8'h00;
    en80 = 1'b1; d80 = 8'h12;
    @(posedge clk); #1;
    check("ones_q108", 128'(q108), 128'({108{1'b1}}));
    check("load_q80", 128'(q80), 128'(8'h12));
    #2;
    d8 = 8'hAA;
    reset = 1'b1;
    #1;
    check("async_q108", 128'(q108), 128'(0));
    check("async_q80", 128'(q80), 128'(8'h80));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rsthold_q108", 128'(q108), 128'(0));
      check("rstprio_q8", 128'(q8), 128'(0));
      check("rsthold_q80", 128'(q80), 128'(8'h80));
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_q8", 128'(q8), 128'(0));
    @(posedge clk); #1;
    check("post_q8", 128'(q8), 128'(8'hAA));
    check("post_q108", 128'(q108), 128'({108{1'b1}}));
    check("post_q80", 128'(q80), 128'(8'h12));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
